// File: rtl/acq_sequencer.sv
// Acquisition sequencer: starts the recording memory master, waits for a full buffer
// (optionally bounded by a timeout), then streams the RAM contents out oldest-first.
module acq_sequencer #(
  parameter int RAM_SIZE = 256,
  parameter int ADDR_BUS = 8,
  parameter int DATA_W   = 16
) (
  input  logic                ref_clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                abort,
  input  logic [15:0]         timeout_val,
  output logic                mm_clear,
  output logic                mm_start,
  input  logic                mm_buffer_full,
  input  logic [ADDR_BUS-1:0] mm_ram_ptr,
  output logic [ADDR_BUS-1:0] rd_addr,
  output logic                rd_read,
  input  logic                rd_waitrequest,
  input  logic                rd_readdatavalid,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sop,
  output logic                out_eop,
  output logic                busy,
  output logic                timeout_flag
);

  localparam logic [ADDR_BUS:0] C_SIZE = (ADDR_BUS+1)'(RAM_SIZE);
  localparam logic [ADDR_BUS:0] C_LAST = (ADDR_BUS+1)'(RAM_SIZE - 1);
  localparam logic [ADDR_BUS:0] C_ONE  = (ADDR_BUS+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_START, S_WAIT, S_RD_REQ, S_RD_WAIT, S_OUT
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_BUS-1:0] r_base;
  logic [ADDR_BUS:0]   r_idx;
  logic [15:0]         r_cnt;
  logic [DATA_W-1:0]   r_outData;
  logic                r_timeout;
  logic                r_closing;
  logic                r_abortPend;

  logic [ADDR_BUS:0]   w_sum;
  logic [15:0]         w_cntNext;
  logic                w_latchBase;
  logic                w_incIdx;
  logic                w_capture;
  logic                w_setTimeout;
  logic                w_clrTimeout;
  logic                w_close;
  logic                w_open;
  logic                w_setPend;

  assign w_sum     = {1'b0, r_base} + r_idx;
  assign w_cntNext = r_cnt + 16'd1;

  always_ff @(posedge ref_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // CLEAR both opens and closes an acquisition; r_closing selects START or IDLE after it.
  always_comb begin
    w_nextState  = r_state;
    w_latchBase  = 1'b0;
    w_incIdx     = 1'b0;
    w_capture    = 1'b0;
    w_setTimeout = 1'b0;
    w_clrTimeout = 1'b0;
    w_close      = 1'b0;
    w_open       = 1'b0;
    w_setPend    = 1'b0;
    case (r_state)
      S_IDLE: if (arm) begin
        w_nextState  = S_CLEAR;
        w_clrTimeout = 1'b1;
        w_open       = 1'b1;
      end
      S_CLEAR: w_nextState = r_closing ? S_IDLE : S_START;
      S_START: w_nextState = S_WAIT;
      S_WAIT: begin
        if (abort) begin
          w_nextState = S_CLEAR;
          w_close     = 1'b1;
        end else if (mm_buffer_full) begin
          w_nextState = S_RD_REQ;
          w_latchBase = 1'b1;
        end else if (timeout_val != 16'd0 && w_cntNext == timeout_val) begin
          w_nextState  = S_CLEAR;
          w_close      = 1'b1;
          w_setTimeout = 1'b1;
        end
      end
      // A stalled read must stay asserted, so an abort there waits for the response.
      S_RD_REQ: begin
        if (!rd_waitrequest) begin
          if (abort) begin
            w_nextState = S_CLEAR;
            w_close     = 1'b1;
          end else begin
            w_nextState = S_RD_WAIT;
          end
        end else if (abort) begin
          w_setPend = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (rd_readdatavalid) begin
          if (r_abortPend || abort) begin
            w_nextState = S_CLEAR;
            w_close     = 1'b1;
          end else begin
            w_nextState = S_OUT;
            w_capture   = 1'b1;
          end
        end else if (abort) begin
          w_setPend = 1'b1;
        end
      end
      S_OUT: begin
        if (abort || (out_ready && r_idx == C_LAST)) begin
          w_nextState = S_CLEAR;
          w_close     = 1'b1;
        end else if (out_ready) begin
          w_nextState = S_RD_REQ;
          w_incIdx    = 1'b1;
        end
      end
      default: w_nextState = S_IDLE;
    endcase

    mm_clear     = reset || (r_state == S_CLEAR);
    mm_start     = !reset && (r_state == S_START);
    rd_read      = !reset && (r_state == S_RD_REQ);
    out_valid    = !reset && (r_state == S_OUT);
    out_sop      = out_valid && (r_idx == '0);
    out_eop      = out_valid && (r_idx == C_LAST);
    busy         = !reset && (r_state != S_IDLE);
    out_data     = r_outData;
    timeout_flag = r_timeout;
    rd_addr      = (w_sum >= C_SIZE) ? ADDR_BUS'(w_sum - C_SIZE) : ADDR_BUS'(w_sum);
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_base      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_outData   <= '0;
      r_timeout   <= 1'b0;
      r_closing   <= 1'b0;
      r_abortPend <= 1'b0;
    end else begin
      if (r_state == S_START)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= w_cntNext;

      if (w_latchBase) begin
        r_base <= mm_ram_ptr;
        r_idx  <= '0;
      end else if (w_incIdx) begin
        r_idx <= r_idx + C_ONE;
      end

      if (w_capture) r_outData <= rd_data;

      if (w_clrTimeout)      r_timeout <= 1'b0;
      else if (w_setTimeout) r_timeout <= 1'b1;

      if (w_open)       r_closing <= 1'b0;
      else if (w_close) r_closing <= 1'b1;

      if (r_state == S_IDLE || r_state == S_CLEAR) r_abortPend <= 1'b0;
      else if (w_setPend)                          r_abortPend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: memory-master and Avalon slave models feed a
// scoreboard of expected samples that is drained on every output handshake.
module tb_acq_sequencer;

  logic        ref_clk;
  logic        reset;
  logic        arm;
  logic        abort;
  logic [15:0] timeout_val;
  logic        mm_clear;
  logic        mm_start;
  logic        mm_buffer_full;
  logic [7:0]  mm_ram_ptr;
  logic [7:0]  rd_addr;
  logic        rd_read;
  logic        rd_waitrequest;
  logic        rd_readdatavalid;
  logic [15:0] rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        busy;
  logic        timeout_flag;

  acq_sequencer #(.RAM_SIZE(256), .ADDR_BUS(8), .DATA_W(16)) dut (
    .ref_clk(ref_clk), .reset(reset), .arm(arm), .abort(abort),
    .timeout_val(timeout_val), .mm_clear(mm_clear), .mm_start(mm_start),
    .mm_buffer_full(mm_buffer_full), .mm_ram_ptr(mm_ram_ptr),
    .rd_addr(rd_addr), .rd_read(rd_read), .rd_waitrequest(rd_waitrequest),
    .rd_readdatavalid(rd_readdatavalid), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .timeout_flag(timeout_flag)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [256];
  logic [15:0] expQ [$];
  logic [7:0]  frameBase;
  logic [7:0]  heldAddr;
  logic [15:0] heldOut;
  logic [15:0] rdvData;
  int  cyc = 0;
  int  fullDelay = -1;
  int  fullCnt = 0;
  bit  fullArmed = 0;
  int  stallCfg = 0;
  int  stallLeft = 0;
  bit  inRead = 0;
  int  rdvDelay = 0;
  int  rdvCnt = 0;
  bit  rdvPending = 0;
  int  rdvCyc = 0;
  bit  readyRandom = 0;
  int  holdAt = -1;
  bit  outStalled = 0;
  int  readCnt = 0;
  int  sampleCnt = 0;
  int  validCnt = 0;
  int  firstHsCyc = 0;
  int  lastHsCyc = 0;
  int  startCyc = 0;
  int  lastClearCyc = 0;
  int  clearsSinceStart = 0;
  int  busyFallCyc = 0;
  bit  prevBusy = 0;
  bit  prevClear = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: sample at the falling edge, then drive inputs for the next rising edge.
  task automatic tick();
    logic [7:0]  expAddr;
    logic [15:0] expData;
    bit r;
    @(negedge ref_clk);
    cyc++;
    arm = 1'b0;
    abort = 1'b0;

    if (prevBusy && !busy) begin
      busyFallCyc = cyc;
      checkOutput("clr_before_idle", 32'(prevClear), 1);
    end
    prevBusy = busy;
    prevClear = mm_clear;

    if (mm_clear) begin
      fullArmed = 0;
      mm_buffer_full = 1'b0;
      lastClearCyc = cyc;
      clearsSinceStart++;
    end
    if (mm_start) begin
      startCyc = cyc;
      clearsSinceStart = 0;
      fullArmed = (fullDelay >= 0);
      fullCnt = fullDelay;
    end else if (fullArmed) begin
      if (fullCnt == 0) mm_buffer_full = 1'b1;
      else fullCnt--;
    end

    rd_readdatavalid = 1'b0;
    rd_data = 16'($urandom);
    if (rdvPending) begin
      if (rdvCnt == 0) begin
        rd_readdatavalid = 1'b1;
        rd_data = rdvData;
        rdvPending = 0;
        rdvCyc = cyc;
        checkOutput("one_outstanding", 32'(rd_read), 0);
      end else begin
        rdvCnt--;
      end
    end

    rd_waitrequest = 1'b0;
    if (rd_read) begin
      if (!inRead) begin
        inRead = 1;
        stallLeft = stallCfg;
        heldAddr = rd_addr;
        expAddr = frameBase + 8'(readCnt);
        checkOutput("rd_addr", 32'(rd_addr), 32'(expAddr));
      end else begin
        checkOutput("addr_hold", 32'(rd_addr), 32'(heldAddr));
      end
      if (stallLeft > 0) begin
        rd_waitrequest = 1'b1;
        stallLeft--;
      end else begin
        inRead = 0;
        rdvPending = 1;
        rdvCnt = rdvDelay;
        rdvData = mem[rd_addr];
        expQ.push_back(mem[rd_addr]);
        readCnt++;
      end
    end else if (inRead) begin
      checkOutput("read_dropped", 0, 1);
      inRead = 0;
    end

    if (out_valid) begin
      validCnt++;
      if (outStalled) checkOutput("out_hold", 32'(out_data), 32'(heldOut));
      if (sampleCnt == holdAt) r = 0;
      else if (readyRandom) r = 1'($urandom_range(0, 1));
      else r = 1;
      out_ready = r;
      if (r) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_sample", 1, 0);
        end else begin
          expData = expQ.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(expData));
        end
        checkOutput("sop", 32'(out_sop), 32'(sampleCnt == 0));
        checkOutput("eop", 32'(out_eop), 32'(sampleCnt == 255));
        if (sampleCnt == 0) firstHsCyc = cyc;
        lastHsCyc = cyc;
        sampleCnt++;
        outStalled = 0;
      end else begin
        outStalled = 1;
        heldOut = out_data;
      end
    end else begin
      out_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
      outStalled = 0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ptr, input int delay);
    mm_ram_ptr = ptr;
    frameBase = ptr;
    fullDelay = delay;
    readCnt = 0;
    sampleCnt = 0;
    expQ.delete();
    outStalled = 0;
    arm = 1'b1;
    tick();
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(busy), 0);
  endtask

  initial begin
    int validBefore;
    int abortCyc;
    int n;
    reset = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    timeout_val = 16'd0;
    mm_buffer_full = 1'b0;
    mm_ram_ptr = 8'h00;
    rd_waitrequest = 1'b0;
    rd_readdatavalid = 1'b0;
    rd_data = 16'h0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    tick();
    checkOutput("reset_clear", 32'(mm_clear), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();
    checkOutput("reset_outs", {busy, mm_clear, mm_start, rd_read, out_valid, out_sop,
                               out_eop, timeout_flag, rd_addr, out_data}, 0);

    $display("[TB] full frame, base 0x10");
    applyStimulus(8'h10, 49);
    waitIdle(2000, "frame_idle");
    checkOutput("frame_samples", sampleCnt, 256);
    checkOutput("frame_reads", readCnt, 256);
    checkOutput("frame_leftover", expQ.size(), 0);
    checkOutput("frame_rate", lastHsCyc - firstHsCyc, 765);
    checkOutput("frame_tmo", 32'(timeout_flag), 0);

    $display("[TB] timeout of 100 cycles");
    timeout_val = 16'd100;
    validBefore = validCnt;
    applyStimulus(8'h20, -1);
    waitIdle(500, "tmo_idle");
    checkOutput("tmo_flag", 32'(timeout_flag), 1);
    checkOutput("tmo_wait_len", lastClearCyc - startCyc, 101);
    checkOutput("tmo_clears", clearsSinceStart, 1);
    checkOutput("tmo_no_valid", validCnt - validBefore, 0);
    checkOutput("tmo_no_reads", readCnt, 0);

    $display("[TB] buffer full coincides with timeout");
    applyStimulus(8'hF3, 99);
    checkOutput("tmo_cleared_on_arm", 32'(timeout_flag), 0);
    waitIdle(2000, "coin_idle");
    checkOutput("coin_samples", sampleCnt, 256);
    checkOutput("coin_tmo", 32'(timeout_flag), 0);
    timeout_val = 16'd0;

    $display("[TB] stalled reads, random out_ready");
    stallCfg = 3;
    readyRandom = 1;
    applyStimulus(8'h80, 5);
    waitIdle(8000, "stall_idle");
    checkOutput("stall_samples", sampleCnt, 256);
    checkOutput("stall_leftover", expQ.size(), 0);
    stallCfg = 0;
    readyRandom = 0;

    $display("[TB] abort during read wait");
    rdvDelay = 3;
    applyStimulus(8'h00, 2);
    n = 0;
    while (!(sampleCnt >= 3 && rdvPending) && n < 500) begin
      tick();
      n++;
    end
    checkOutput("abort_reached", 32'(sampleCnt >= 3 && rdvPending), 1);
    tick();
    validBefore = validCnt;
    abort = 1'b1;
    waitIdle(200, "abort_idle");
    checkOutput("abort_no_valid", validCnt - validBefore, 0);
    checkOutput("abort_samples", sampleCnt, 3);
    checkOutput("abort_after_rdv", busyFallCyc - rdvCyc, 2);
    checkOutput("abort_discard", expQ.size(), 1);
    expQ.delete();
    rdvDelay = 0;

    $display("[TB] abort ignored in idle, honoured in wait");
    abort = 1'b1;
    tick();
    checkOutput("idle_abort", 32'(busy), 0);
    applyStimulus(8'h40, -1);
    repeat (10) tick();
    abort = 1'b1;
    abortCyc = cyc;
    waitIdle(50, "wait_abort_idle");
    checkOutput("wait_abort_len", busyFallCyc - abortCyc, 2);
    checkOutput("wait_abort_reads", readCnt, 0);
    checkOutput("wait_abort_tmo", 32'(timeout_flag), 0);

    $display("[TB] reset mid-frame at sample 37");
    holdAt = 37;
    applyStimulus(8'h55, 3);
    n = 0;
    while (!(out_valid && sampleCnt == 37) && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("rst_reached", 32'(out_valid && sampleCnt == 37), 1);
    reset = 1'b1;
    prevBusy = 0;
    tick();
    checkOutput("rst_cycle_clear", 32'(mm_clear), 1);
    checkOutput("rst_cycle_outs", {busy, mm_start, rd_read, out_valid, out_sop, out_eop,
                                   timeout_flag, rd_addr, out_data}, 0);
    reset = 1'b0;
    holdAt = -1;
    tick();
    checkOutput("rst_after_outs", {busy, mm_clear, mm_start, rd_read, out_valid, out_sop,
                                   out_eop, timeout_flag, rd_addr, out_data}, 0);
    inRead = 0;
    rdvPending = 0;
    applyStimulus(8'h55, 3);
    waitIdle(2000, "restart_idle");
    checkOutput("restart_samples", sampleCnt, 256);
    checkOutput("restart_leftover", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter RAM_SIZE, 256, depth of the sample RAM written by the recording memory master.
REQ-002 Parameter ADDR_BUS, 8, RAM address width.
REQ-003 Parameter DATA_W, 16, sample width.
REQ-004 ref_clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 arm  in  1  one-cycle request to run one acquisition.
REQ-007 abort  in  1  one-cycle request to cancel the current acquisition.
REQ-008 timeout_val  in  16  max cycles to wait for mm_buffer_full; 0 disables the timeout.
REQ-009 mm_clear  out  1  one-cycle reset pulse to the recording memory master.
REQ-010 mm_start  out  1  one-cycle start pulse to the recording memory master.
REQ-011 mm_buffer_full  in  1  recording complete flag.
REQ-012 mm_ram_ptr  in  ADDR_BUS  memory-master pointer; next address to be written.
REQ-013 rd_addr  out  ADDR_BUS  Avalon-MM read address.
REQ-014 rd_read  out  1  Avalon-MM read request.
REQ-015 rd_waitrequest  in  1  slave stall.
REQ-016 rd_readdatavalid  in  1  read data valid.
REQ-017 rd_data  in  DATA_W  read data.
REQ-018 out_data  out  DATA_W  streamed sample.
REQ-019 out_valid / out_ready  out / in  1 / 1  stream handshake.
REQ-020 out_sop / out_eop  out  1 / 1  first / last sample of a frame.
REQ-021 busy  out  1  high in any state other than IDLE.
REQ-022 timeout_flag  out  1  sticky; last acquisition timed out.

Function
REQ-023 States: IDLE, CLEAR, START, WAIT, RD_REQ, RD_WAIT, OUT; IDLE, CLEAR and START are held 1 cycle except IDLE.
REQ-024 IDLE: arm -> CLEAR; timeout_flag cleared on the same edge.
REQ-025 CLEAR: mm_clear=1 for exactly one cycle -> START.
REQ-026 START: mm_start=1 for exactly one cycle; timeout counter loaded 0 -> WAIT.
REQ-027 WAIT: counter increments each cycle; mm_buffer_full=1 -> latch base=mm_ram_ptr, idx=0 -> RD_REQ; else counter==timeout_val (nonzero) -> timeout_flag=1, -> CLEAR then IDLE (no frame output).
REQ-028 mm_buffer_full and timeout in the same cycle: buffer_full wins, no timeout_flag.
REQ-029 RD_REQ: rd_read=1, rd_addr=(base+idx) mod RAM_SIZE; held stable while rd_waitrequest=1; -> RD_WAIT when rd_waitrequest=0.
REQ-030 At most one read outstanding; rd_read=0 in every state except RD_REQ.
REQ-031 RD_WAIT: on rd_readdatavalid capture rd_data into out_data -> OUT.
REQ-032 OUT: out_valid=1, out_data stable until out_valid&out_ready; out_sop=(idx==0), out_eop=(idx==RAM_SIZE-1).
REQ-033 On handshake: idx==RAM_SIZE-1 -> CLEAR then IDLE; else idx+1 -> RD_REQ.
REQ-034 idx is ADDR_BUS+1 bits; frame is exactly RAM_SIZE samples, oldest first (base), address wraps RAM_SIZE-1 -> 0.
REQ-035 abort in WAIT, RD_REQ (rd_waitrequest=0 or no read issued), OUT -> CLEAR then IDLE, no eop; in RD_WAIT abort is held pending until rd_readdatavalid, data discarded.
REQ-036 arm outside IDLE is ignored; abort in IDLE is ignored.
REQ-037 Throughput bound: one sample per 3 cycles with zero wait states and out_ready=1.

Reset
REQ-038 reset -> IDLE; mm_clear=1 for the reset cycle, all other outputs 0 (rd_addr=0, out_data=0, timeout_flag=0); reset mid-frame truncates without eop.

Verification
REQ-039 arm; mm_buffer_full asserted 50 cycles later with mm_ram_ptr=0x10 -> 256 reads at 0x10..0xFF,0x00..0x0F; sop on first, eop on 256th; busy falls after trailing mm_clear.
REQ-040 timeout_val=100, mm_buffer_full never -> timeout_flag=1 after 100 WAIT cycles, one mm_clear, no out_valid.
REQ-041 rd_waitrequest held 3 cycles, random out_ready -> rd_addr/rd_read and out_data stable while stalled, no sample lost or duplicated.
REQ-042 abort during RD_WAIT -> no out_valid for that read, returns to IDLE after readdatavalid + CLEAR.
REQ-043 mm_buffer_full and timeout coincide -> frame streamed, timeout_flag=0.
REQ-044 reset during OUT at idx=37 -> next cycle all outputs 0, state IDLE; new arm restarts full frame with sop.
